// File: rtl/arb_client_pkg.sv
// Shared definitions for the arbiter and its clients: channel count,
// client FSM state encoding and grant-vector helper functions.
package arb_client_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_ACK   = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_e;

  // True when exactly one bit of the vector is set.
  function automatic logic is_onehot(input logic [NUM_CH-1:0] v);
    logic [NUM_CH-1:0] one;
    one = {{(NUM_CH-1){1'b0}}, 1'b1};
    return (v != {NUM_CH{1'b0}}) && ((v & (v - one)) == {NUM_CH{1'b0}});
  endfunction

  // True when two or more bits of the vector are set.
  function automatic logic is_multi(input logic [NUM_CH-1:0] v);
    logic [NUM_CH-1:0] one;
    one = {{(NUM_CH-1){1'b0}}, 1'b1};
    return (v & (v - one)) != {NUM_CH{1'b0}};
  endfunction

  // Index of the set bit of a one-hot vector (0 for a zero vector).
  function automatic logic [CH_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] v);
    logic [CH_W-1:0] idx;
    idx = {CH_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i]) begin
        idx = CH_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_client_req_slot.sv
// One channel's request holding register: a pending flag plus the payload
// captured when the request was accepted. The slot refuses new requests
// while pending, so the payload stays stable for the whole transfer.
module req_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [DW-1:0] req_data,
  input  logic          clr,
  output logic          req_ready,
  output logic          pending,
  output logic [DW-1:0] data
);

  logic          pending_d, pending_q;
  logic [DW-1:0] data_d, data_q;
  logic          accept_s;

  // Next-state: accept when empty, clear when the transfer is acknowledged.
  always_comb begin
    pending_d = pending_q;
    data_d    = data_q;
    accept_s  = req_valid && !pending_q;
    if (accept_s) begin
      pending_d = 1'b1;
      data_d    = req_data;
    end else if (clr) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Slot state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= 1'b0;
      data_q    <= {DW{1'b0}};
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

  assign req_ready = !pending_q;
  assign pending   = pending_q;
  assign data      = data_q;

endmodule

// File: rtl/arb_client.sv
// Arbiter client: collects per-channel requests, presents the pending vector
// to the arbiter, and on a one-hot grant sends that channel's payload
// downstream, acknowledges completion, then waits out a guard interval
// before sampling the grant again.
module arb_client
  import arb_client_pkg::*;
#(
  parameter int DW    = 8,
  parameter int GUARD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH*DW-1:0] req_data,
  output logic [NUM_CH-1:0]    req_ready,
  output logic [NUM_CH-1:0]    reg_out,
  input  logic [NUM_CH-1:0]    grant,
  output logic                 ack,
  output logic                 tx_valid,
  output logic [DW-1:0]        tx_data,
  output logic [CH_W-1:0]      tx_ch,
  input  logic                 tx_ready,
  output logic                 err
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD > 0) ? (GUARD - 1) : 0);

  arb_state_e      state_d, state_q;
  logic            tx_valid_d, tx_valid_q;
  logic [DW-1:0]   tx_data_d, tx_data_q;
  logic [CH_W-1:0] tx_ch_d, tx_ch_q;
  logic            ack_d, ack_q;
  logic            err_d, err_q;
  logic [GW-1:0]   guard_cnt_d, guard_cnt_q;

  logic [NUM_CH-1:0] pending_s;
  logic [NUM_CH-1:0] clr_s;
  logic [DW-1:0]     slot_data_s [NUM_CH];
  logic [CH_W-1:0]   grant_idx_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    // The acknowledged channel is released at the end of the ACK cycle.
    assign clr_s[i] = (state_q == ST_ACK) && (tx_ch_q == CH_W'(i));

    req_slot #(.DW(DW)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[i]),
      .req_data  (req_data[i*DW +: DW]),
      .clr       (clr_s[i]),
      .req_ready (req_ready[i]),
      .pending   (pending_s[i]),
      .data      (slot_data_s[i])
    );
  end

  assign reg_out = pending_s;

  // FSM next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    tx_ch_d     = tx_ch_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    guard_cnt_d = guard_cnt_q;
    grant_idx_s = onehot_to_idx(grant);
    case (state_q)
      ST_IDLE: begin
        if (is_onehot(grant) && ((grant & pending_s) != {NUM_CH{1'b0}})) begin
          state_d    = ST_SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = slot_data_s[grant_idx_s];
          tx_ch_d    = grant_idx_s;
        end else if (is_multi(grant)) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        // Grant is deliberately ignored here: the transfer always completes.
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          ack_d      = 1'b1;
          state_d    = ST_ACK;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_ACK: begin
        guard_cnt_d = {GW{1'b0}};
        if (GUARD == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) begin
          guard_cnt_d = {GW{1'b0}};
          state_d     = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        tx_valid_d  = 1'b0;
        guard_cnt_d = {GW{1'b0}};
      end
    endcase
  end

  // FSM state and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= {DW{1'b0}};
      tx_ch_q     <= {CH_W{1'b0}};
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      guard_cnt_q <= {GW{1'b0}};
    end else begin
      state_q     <= state_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      tx_ch_q     <= tx_ch_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_ch    = tx_ch_q;
  assign ack      = ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_arb_client.sv
// Randomized self-checking bench for arb_client. The reference model tracks
// pending requests and payloads in arrays and derives the handshake timing
// from cycle arithmetic: tx_valid the cycle after an accepted grant, ack the
// cycle after the tx handshake, and grant sampling resuming GUARD cycles
// after the ack cycle.
module tb_arb_client;

  localparam int DW    = 8;
  localparam int GUARD = 2;

  logic            clk;
  logic            rst;
  logic [3:0]      req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_ready;
  logic [3:0]      reg_out;
  logic [3:0]      grant;
  logic            ack;
  logic            tx_valid;
  logic [DW-1:0]   tx_data;
  logic [1:0]      tx_ch;
  logic            tx_ready;
  logic            err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit            m_pend [4];
  logic [DW-1:0] m_pl   [4];
  bit            m_txv;
  bit            m_ack;
  bit            m_err;
  int            m_ch;
  logic [DW-1:0] m_txd;
  int            cyc;
  int            resume;

  arb_client #(.DW(DW), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .reg_out   (reg_out),
    .grant     (grant),
    .ack       (ack),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ch     (tx_ch),
    .tx_ready  (tx_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] pend_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic compare_outputs();
    logic [3:0] pv;
    pv = pend_vec();
    check_eq("tx_valid", {31'd0, tx_valid}, {31'd0, m_txv});
    check_eq("ack", {31'd0, ack}, {31'd0, m_ack});
    check_eq("err", {31'd0, err}, {31'd0, m_err});
    check_eq("reg_out", {28'd0, reg_out}, {28'd0, pv});
    check_eq("req_ready", {28'd0, req_ready}, {28'd0, ~pv});
    if (m_txv) begin
      check_eq("tx_ch", {30'd0, tx_ch}, m_ch);
      check_eq("tx_data", {24'd0, tx_data}, {24'd0, m_txd});
    end
  endtask

  // One clock cycle: check current outputs, drive inputs, advance the model.
  task automatic step(input logic [3:0] rv, input logic [4*DW-1:0] rd,
                      input logic [3:0] gr, input logic tr);
    bit            n_txv;
    bit            n_ack;
    bit            n_err;
    int            n_ch;
    logic [DW-1:0] n_txd;
    bit            idle;
    @(negedge clk);
    compare_outputs();
    req_valid = rv;
    req_data  = rd;
    grant     = gr;
    tx_ready  = tr;
    n_ack = m_txv && tr;
    n_txv = m_txv && !tr;
    n_ch  = m_ch;
    n_txd = m_txd;
    n_err = 1'b0;
    idle  = !m_txv && !m_ack && (cyc >= resume);
    if (idle) begin
      if ($countones(gr) == 1) begin
        for (int i = 0; i < 4; i++) begin
          if (gr[i] && m_pend[i]) begin
            n_txv = 1'b1;
            n_ch  = i;
            n_txd = m_pl[i];
          end
        end
      end else if ($countones(gr) > 1) begin
        n_err = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (rv[i] && !m_pend[i]) begin
        m_pend[i] = 1'b1;
        m_pl[i]   = rd[i*DW +: DW];
      end
    end
    if (m_ack) begin
      m_pend[m_ch] = 1'b0;
      resume       = cyc + 1 + GUARD;
    end
    m_txv = n_txv;
    m_ack = n_ack;
    m_err = n_err;
    m_ch  = n_ch;
    m_txd = n_txd;
    cyc++;
  endtask

  // Assert reset between clock edges and check outputs clear immediately.
  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0000;
    req_data  = '0;
    grant     = 4'b0000;
    tx_ready  = 1'b0;
    #1;
    check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_ack", {31'd0, ack}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst_tx_ch", {30'd0, tx_ch}, 32'd0);
    check_eq("rst_reg_out", {28'd0, reg_out}, 32'd0);
    check_eq("rst_req_ready", {28'd0, req_ready}, 32'h0000_000f);
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 1'b0;
      m_pl[i]   = '0;
    end
    m_txv  = 1'b0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
    m_ch   = 0;
    m_txd  = '0;
    resume = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step(4'b0000, '0, 4'b0000, 1'b0);
  endtask

  initial begin
    logic [3:0]      g;
    logic [3:0]      rv;
    logic [4*DW-1:0] rd;
    int              sel;
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = '0;
    grant     = 4'b0000;
    tx_ready  = 1'b0;
    cyc       = 0;
    apply_reset();

    // Single request on channel 0 with payload A5
    step(4'b0001, {24'd0, 8'hA5}, 4'b0000, 1'b0);
    step(4'b0000, '0, 4'b0001, 1'b1);
    step(4'b0000, '0, 4'b0000, 1'b1);
    idle_cycles(4);

    // Backpressure for five cycles
    step(4'b0001, {24'd0, 8'h3C}, 4'b0000, 1'b0);
    step(4'b0000, '0, 4'b0001, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b0000, '0, 4'b0110, 1'b0);
    step(4'b0000, '0, 4'b0000, 1'b1);
    idle_cycles(4);

    // Illegal multi-bit grant with both channels pending
    step(4'b0101, {8'h00, 8'h22, 8'h00, 8'h11}, 4'b0000, 1'b0);
    step(4'b0000, '0, 4'b0101, 1'b1);
    idle_cycles(2);

    // Flush channels 0 and 2
    step(4'b0000, '0, 4'b0001, 1'b1);
    step(4'b0000, '0, 4'b0000, 1'b1);
    idle_cycles(3);
    step(4'b0000, '0, 4'b0100, 1'b1);
    step(4'b0000, '0, 4'b0000, 1'b1);
    idle_cycles(3);

    // Grant to a non-pending channel, then to the pending one
    step(4'b0010, {16'd0, 8'h77, 8'h00}, 4'b0000, 1'b0);
    step(4'b0000, '0, 4'b1000, 1'b1);
    idle_cycles(2);
    step(4'b0000, '0, 4'b0010, 1'b1);
    step(4'b0000, '0, 4'b0000, 1'b1);
    idle_cycles(3);

    // Re-request on channel 2 during its ACK cycle
    step(4'b0100, {8'h00, 8'h5A, 16'd0}, 4'b0000, 1'b0);
    step(4'b0000, '0, 4'b0100, 1'b1);
    step(4'b0000, '0, 4'b0000, 1'b1);
    step(4'b0100, {8'h00, 8'hC3, 16'd0}, 4'b0000, 1'b0);
    step(4'b0100, {8'h00, 8'h96, 16'd0}, 4'b0000, 1'b0);
    idle_cycles(3);
    step(4'b0000, '0, 4'b0100, 1'b1);
    step(4'b0000, '0, 4'b0000, 1'b1);
    idle_cycles(3);

    // Reset while a transfer is in SEND
    step(4'b1001, {8'hE1, 16'd0, 8'h1E}, 4'b0000, 1'b0);
    step(4'b0000, '0, 4'b1000, 1'b0);
    step(4'b0000, '0, 4'b0000, 1'b0);
    apply_reset();
    idle_cycles(3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rv  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rd  = {$urandom};
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        g = 4'b0001 << $urandom_range(0, 3);
      end else if (sel <= 6) begin
        g = 4'b0000;
      end else if (sel == 7) begin
        g = 4'($urandom_range(0, 15));
        while ($countones(g) < 2) g = 4'($urandom_range(0, 15));
      end else begin
        g = 4'b0001 << $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) begin
          if (m_pend[i] && ($urandom_range(0, 1) == 1)) g = 4'b0001 << i;
        end
      end
      step(rv, rd, g, 1'($urandom_range(0, 9) < 7));
      if (m_txv && ($urandom_range(0, 80) == 0)) begin
        apply_reset();
      end
    end
    idle_cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
